isp_awb_gray_world: RTL

// - Parametrised gray-world auto white balance for the ISP RGB path. It sits after demosaic and before CCM/gamma.
// - It gathers per-frame R/G/B sums, computes Q-format gains with a sequential divider, and applies them to the next frame.
// - Adds manual/auto gain mode, exclusion of clipped pixels from the statistics, and frame-boundary-safe gain commit.

---
 rtl/isp_awb_gray_world_pkg.sv | 19 +
 rtl/awb_seq_div.sv | 80 ++++++++
 rtl/isp_awb_gray_world.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/isp_awb_gray_world_pkg.sv
// Shared types and constants for the gray-world AWB block: FSM encoding,
// apply-path latency and the statistics accumulator width rule.
package isp_awb_gray_world_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV_R = 2'd1,
        ST_DIV_B = 2'd2,
        ST_PEND  = 2'd3
    } awb_state_t;

    localparam int PIPE_LAT = 3;

    // Wide enough to hold a full frame of maximum-valued pixels.
    function automatic int calc_acc_w(input int data_w, input int npix);
        return data_w + $clog2(npix);
    endfunction

endpackage

// File: rtl/awb_seq_div.sv
// Restoring divider, one quotient bit per cycle, with saturation to Q_W bits
// and unity result on a zero divisor or zero dividend.
module awb_seq_div #(
    parameter int DVD_W = 23,
    parameter int DVS_W = 13,
    parameter int Q_W   = 12,
    parameter int FRAC  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);
    localparam int CNT_W = $clog2(DVD_W + 1);
    localparam logic [Q_W-1:0]   UNITY = Q_W'(1) << FRAC;
    localparam logic [DVD_W-1:0] Q_MAX = DVD_W'(2**Q_W - 1);

    logic [DVS_W-1:0] dvs;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] rem_nxt;
    logic [DVS_W:0]   trial;
    logic [DVD_W-1:0] quo;
    logic [DVD_W-1:0] quo_nxt;
    logic [CNT_W-1:0] cnt;
    logic             zero_op;

    // The dividend shifts out of quo while quotient bits shift in behind it.
    always_comb begin
        trial = {rem, quo[DVD_W-1]};
        if (trial >= {1'b0, dvs}) begin
            rem_nxt = trial[DVS_W-1:0] - dvs;
            quo_nxt = {quo[DVD_W-2:0], 1'b1};
        end else begin
            rem_nxt = trial[DVS_W-1:0];
            quo_nxt = {quo[DVD_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            zero_op  <= 1'b0;
            quotient <= UNITY;
        end else begin
            done <= 1'b0;
            if (busy) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (zero_op)
                        quotient <= UNITY;
                    else if (quo_nxt > Q_MAX)
                        quotient <= '1;
                    else
                        quotient <= quo_nxt[Q_W-1:0];
                end
            end else if (start) begin
                busy    <= 1'b1;
                cnt     <= CNT_W'(DVD_W);
                dvs     <= divisor;
                rem     <= '0;
                quo     <= dividend;
                zero_op <= (divisor == '0) || (dividend == '0);
            end
        end
    end

endmodule

// File: rtl/isp_awb_gray_world.sv
// Gray-world auto white balance: per-frame statistics, sequential gain divide, 3-stage apply.
// Define AWB_IIR_EN to smooth committed auto gains (old + (new-old)>>>2).
//
// state | meaning
// IDLE  | waiting for a frame end to start a gain computation
// DIV_R | dividing sum_g<<GAIN_FRAC by sum_r
// DIV_B | dividing sum_g<<GAIN_FRAC by sum_b
// PEND  | new gains ready, waiting for inter-frame blanking to commit
module isp_awb_gray_world
    import isp_awb_gray_world_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int IMG_HDISP = 1936,
    parameter int IMG_VDISP = 1088,
    parameter int GAIN_FRAC = 10,
    parameter int GAIN_W    = 12,
    parameter int CLIP_LO   = 8,
    parameter int CLIP_HI   = 247
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                per_img_clken,
    input  logic [3*DATA_W-1:0] per_img_data,
    input  logic                awb_auto,
    input  logic [GAIN_W-1:0]   manual_gain_r,
    input  logic [GAIN_W-1:0]   manual_gain_g,
    input  logic [GAIN_W-1:0]   manual_gain_b,
    output logic                post_img_clken,
    output logic [3*DATA_W-1:0] post_img_data,
    output logic [GAIN_W-1:0]   gain_r,
    output logic [GAIN_W-1:0]   gain_g,
    output logic [GAIN_W-1:0]   gain_b,
    output logic                gain_upd,
    output logic                stat_drop
);
    localparam int NPIX   = IMG_HDISP * IMG_VDISP;
    localparam int CNT_W  = $clog2(NPIX);
    localparam int ACC_W  = calc_acc_w(DATA_W, NPIX);
    localparam int DVD_W  = ACC_W + GAIN_FRAC;
    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int RND_W  = PROD_W + 1 - GAIN_FRAC;

    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(1) << GAIN_FRAC;
    localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(NPIX - 1);
    localparam logic [DATA_W-1:0] LO       = DATA_W'(CLIP_LO);
    localparam logic [DATA_W-1:0] HI       = DATA_W'(CLIP_HI);
    localparam logic [PROD_W:0]   HALF     = (PROD_W + 1)'(1) << (GAIN_FRAC - 1);
    localparam logic [RND_W-1:0]  PIX_MAX  = RND_W'(2**DATA_W - 1);

    logic [DATA_W-1:0] pix_r, pix_g, pix_b;
    assign pix_r = per_img_data[3*DATA_W-1 -: DATA_W];
    assign pix_g = per_img_data[2*DATA_W-1 -: DATA_W];
    assign pix_b = per_img_data[DATA_W-1:0];

    logic             in_range;
    logic             frame_end;
    logic [CNT_W-1:0] pix_cnt;
    logic [ACC_W-1:0] acc_r, acc_g, acc_b;
    logic [ACC_W-1:0] add_r, add_g, add_b;
    logic [ACC_W-1:0] sum_r, sum_g, sum_b;

    assign in_range = (pix_r >= LO) && (pix_r <= HI) &&
                      (pix_g >= LO) && (pix_g <= HI) &&
                      (pix_b >= LO) && (pix_b <= HI);
    assign frame_end = per_img_clken && (pix_cnt == LAST_PIX);
    assign add_r = in_range ? ACC_W'(pix_r) : '0;
    assign add_g = in_range ? ACC_W'(pix_g) : '0;
    assign add_b = in_range ? ACC_W'(pix_b) : '0;
    assign sum_r = acc_r + add_r;
    assign sum_g = acc_g + add_g;
    assign sum_b = acc_b + add_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt <= '0;
            acc_r   <= '0;
            acc_g   <= '0;
            acc_b   <= '0;
        end else if (per_img_clken) begin
            if (frame_end) begin
                pix_cnt <= '0;
                acc_r   <= '0;
                acc_g   <= '0;
                acc_b   <= '0;
            end else begin
                pix_cnt <= pix_cnt + 1'b1;
                acc_r   <= sum_r;
                acc_g   <= sum_g;
                acc_b   <= sum_b;
            end
        end
    end

    awb_state_t        state;
    logic [ACC_W-1:0]  lat_r, lat_g, lat_b;
    logic [GAIN_W-1:0] new_r, new_b;
    logic [GAIN_W-1:0] commit_r, commit_b;
    logic              div_start, div_busy, div_done;
    logic [GAIN_W-1:0] div_q;

    awb_seq_div #(
        .DVD_W (DVD_W),
        .DVS_W (ACC_W),
        .Q_W   (GAIN_W),
        .FRAC  (GAIN_FRAC)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({lat_g, {GAIN_FRAC{1'b0}}}),
        .divisor  ((state == ST_DIV_B) ? lat_b : lat_r),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

`ifdef AWB_IIR_EN
    function automatic logic [GAIN_W-1:0] iir_step(input logic [GAIN_W-1:0] old_g,
                                                   input logic [GAIN_W-1:0] tgt_g);
        logic signed [GAIN_W+1:0] diff;
        diff = $signed({2'b00, tgt_g}) - $signed({2'b00, old_g});
        diff = diff >>> 2;
        return GAIN_W'($signed({2'b00, old_g}) + diff);
    endfunction

    assign commit_r = iir_step(gain_r, new_r);
    assign commit_b = iir_step(gain_b, new_b);
`else
    assign commit_r = new_r;
    assign commit_b = new_b;
`endif

    assign gain_g = UNITY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_start <= 1'b0;
            lat_r     <= '0;
            lat_g     <= '0;
            lat_b     <= '0;
            new_r     <= UNITY;
            new_b     <= UNITY;
            gain_r    <= UNITY;
            gain_b    <= UNITY;
            gain_upd  <= 1'b0;
            stat_drop <= 1'b0;
        end else begin
            div_start <= 1'b0;
            gain_upd  <= 1'b0;
            stat_drop <= frame_end && ((state != ST_IDLE) || div_busy);
            case (state)
                ST_IDLE: if (frame_end && !div_busy) begin
                    lat_r     <= sum_r;
                    lat_g     <= sum_g;
                    lat_b     <= sum_b;
                    div_start <= 1'b1;
                    state     <= ST_DIV_R;
                end
                ST_DIV_R: if (div_done) begin
                    new_r     <= div_q;
                    div_start <= 1'b1;
                    state     <= ST_DIV_B;
                end
                ST_DIV_B: if (div_done) begin
                    new_b <= div_q;
                    state <= ST_PEND;
                end
                // Commit only in blanking so a frame never sees two gain sets.
                ST_PEND: if ((pix_cnt == '0) && !per_img_clken) begin
                    gain_r   <= commit_r;
                    gain_b   <= commit_b;
                    gain_upd <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    function automatic logic [RND_W-1:0] round_shift(input logic [PROD_W-1:0] prod);
        return RND_W'(({1'b0, prod} + HALF) >> GAIN_FRAC);
    endfunction

    function automatic logic [DATA_W-1:0] clamp_pix(input logic [RND_W-1:0] rnd);
        return (rnd > PIX_MAX) ? {DATA_W{1'b1}} : rnd[DATA_W-1:0];
    endfunction

    logic [GAIN_W-1:0]   sel_r, sel_g, sel_b;
    logic [PIPE_LAT-1:0] vld;
    logic [PROD_W-1:0]   prod_r, prod_g, prod_b;
    logic [RND_W-1:0]    rnd_r, rnd_g, rnd_b;

    assign sel_r = awb_auto ? gain_r : manual_gain_r;
    assign sel_g = awb_auto ? gain_g : manual_gain_g;
    assign sel_b = awb_auto ? gain_b : manual_gain_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld           <= '0;
            prod_r        <= '0;
            prod_g        <= '0;
            prod_b        <= '0;
            rnd_r         <= '0;
            rnd_g         <= '0;
            rnd_b         <= '0;
            post_img_data <= '0;
        end else begin
            vld <= {vld[PIPE_LAT-2:0], per_img_clken};
            if (per_img_clken) begin
                prod_r <= PROD_W'(pix_r) * PROD_W'(sel_r);
                prod_g <= PROD_W'(pix_g) * PROD_W'(sel_g);
                prod_b <= PROD_W'(pix_b) * PROD_W'(sel_b);
            end
            if (vld[0]) begin
                rnd_r <= round_shift(prod_r);
                rnd_g <= round_shift(prod_g);
                rnd_b <= round_shift(prod_b);
            end
            if (vld[1])
                post_img_data <= {clamp_pix(rnd_r), clamp_pix(rnd_g), clamp_pix(rnd_b)};
        end
    end

    assign post_img_clken = vld[PIPE_LAT-1];

endmodule
